// File: rtl/fill_arbiter_pkg.sv
// Shared widths, tag-word field positions, port identifiers and FSM encoding
// for the DRAM-cache fill arbiter.
package fill_arbiter_pkg;

   localparam int AXI_ADDR_WIDTH = 64;
   localparam int AXI_DATA_WIDTH = 64;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int OFFSET_WIDTH   = 6;
   localparam int INDEX_WIDTH    = 16;
   localparam int BLANK_WIDTH    = 4;
   localparam int TAG_WIDTH      = AXI_ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int TAG_SIZE       = 2 + TAG_WIDTH + BLANK_WIDTH;

   // Tag-word flag positions counted down from the tag-word MSB
   localparam int TW_VALID_FROM_MSB = 0;
   localparam int TW_DIRTY_FROM_MSB = 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

endpackage

// File: rtl/fill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port
// that did not win last time.
module fill_arbiter_rr_arbiter2
   import fill_arbiter_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  req_a_i,
   input  logic  req_b_i,
   input  logic  en_i,
   output logic  gnt_a_o,
   output logic  gnt_b_o,
   output port_e port_o
);

   port_e last_q;
   port_e last_d;

   // grant decision and last-winner update
   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      if (!en_i) begin
         gnt_a_o = 1'b0;
      end else if (req_a_i && req_b_i) begin
         if (last_q == PORT_B) begin
            gnt_a_o = 1'b1;
         end else begin
            gnt_b_o = 1'b1;
         end
      end else if (req_a_i) begin
         gnt_a_o = 1'b1;
      end else if (req_b_i) begin
         gnt_b_o = 1'b1;
      end else begin
         gnt_a_o = 1'b0;
      end

      if (gnt_a_o) begin
         last_d = PORT_A;
      end else if (gnt_b_o) begin
         last_d = PORT_B;
      end else begin
         last_d = last_q;
      end

      port_o = gnt_b_o ? PORT_B : PORT_A;
   end

   // last-winner register; reset to B so port A wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fill_arbiter.sv
// Merges dirty fills (port A) and clean refills (port B) into single-beat AXI
// writes of {valid, dirty, tag, blank, data}, bounding outstanding B responses.
module fill_arbiter
   import fill_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH      = AXI_DATA_WIDTH,
   parameter int ID_WIDTH        = AXI_ID_WIDTH,
   parameter int TAG_SIZE        = fill_arbiter_pkg::TAG_SIZE,
   parameter int TAG_WIDTH       = fill_arbiter_pkg::TAG_WIDTH,
   parameter int BLANK_WIDTH     = fill_arbiter_pkg::BLANK_WIDTH,
   parameter int INDEX_WIDTH     = fill_arbiter_pkg::INDEX_WIDTH,
   parameter int OFFSET_WIDTH    = fill_arbiter_pkg::OFFSET_WIDTH,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           fill_valid_i,
   output logic                           fill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
   input  logic                           refill_valid_i,
   output logic                           refill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
   output logic                           awvalid_o,
   input  logic                           awready_i,
   output logic [ID_WIDTH-1:0]            awid_o,
   output logic [ADDR_WIDTH-1:0]          awaddr_o,
   output logic                           wvalid_o,
   input  logic                           wready_i,
   output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
   output logic                           wlast_o,
   input  logic                           bvalid_i,
   output logic                           bready_o,
   input  logic [ID_WIDTH-1:0]            bid_i
);

   localparam int LINE_W    = ADDR_WIDTH + DATA_WIDTH;
   localparam int IO_W      = INDEX_WIDTH + OFFSET_WIDTH;
   localparam int WORD_W    = TAG_SIZE + DATA_WIDTH;
   localparam int VALID_POS = TAG_SIZE - 1 - TW_VALID_FROM_MSB;
   localparam int DIRTY_POS = TAG_SIZE - 1 - TW_DIRTY_FROM_MSB;
   localparam int CRED_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);
   localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

   state_e              state_q, state_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic [ID_WIDTH-1:0] awid_q, awid_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [CRED_W-1:0]   credits_q, credits_d;

   logic                arb_en_s;
   logic                gnt_a_s;
   logic                gnt_b_s;
   logic                grant_s;
   logic                b_dec_s;
   port_e               port_s;
   logic [LINE_W-1:0]   sel_line_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic [TAG_SIZE-1:0] tag_word_s;
   logic                unused_bid_s;

   assign arb_en_s       = (state_q == S_IDLE) && (credits_q < CRED_MAX);
   assign grant_s        = gnt_a_s | gnt_b_s;
   assign b_dec_s        = bvalid_i && (credits_q != {CRED_W{1'b0}});
   assign fill_ready_o   = gnt_a_s;
   assign refill_ready_o = gnt_b_s;
   assign awvalid_o      = awvalid_q;
   assign wvalid_o       = wvalid_q;
   assign awid_o         = awid_q;
   assign awaddr_o       = awaddr_q;
   assign wdata_o        = wdata_q;
   assign wlast_o        = 1'b1;
   assign bready_o       = 1'b1;
   assign unused_bid_s   = ^bid_i;

   fill_arbiter_rr_arbiter2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a_i (fill_valid_i),
      .req_b_i (refill_valid_i),
      .en_i    (arb_en_s),
      .gnt_a_o (gnt_a_s),
      .gnt_b_o (gnt_b_s),
      .port_o  (port_s)
   );

   // granted line and its stored tag word
   always_comb begin
      if (gnt_b_s) begin
         sel_line_s = refill_data_i;
      end else begin
         sel_line_s = fill_data_i;
      end
      sel_addr_s = sel_line_s[LINE_W-1 -: ADDR_WIDTH];
      sel_data_s = sel_line_s[DATA_WIDTH-1:0];
      tag_word_s = {TAG_SIZE{1'b0}};
      tag_word_s[VALID_POS] = 1'b1;
      tag_word_s[DIRTY_POS] = (port_s == PORT_A);
      tag_word_s[BLANK_WIDTH +: TAG_WIDTH] = sel_addr_s[ADDR_WIDTH-1:IO_W];
   end

   // grant/send sequencing; payload frozen from grant until both handshakes
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      awid_d    = awid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_s) begin
               state_d   = S_SEND;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awid_d    = ID_WIDTH'((port_s == PORT_B) ? 1'b1 : 1'b0);
               awaddr_d  = ADDR_WIDTH'(sel_addr_s[IO_W-1:0]);
               wdata_d   = {tag_word_s, sel_data_s};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            awvalid_d = awvalid_q & ~awready_i;
            wvalid_d  = wvalid_q & ~wready_i;
            if (!awvalid_d && !wvalid_d) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_SEND;
            end
         end
         default: begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
         end
      endcase
   end

   // outstanding-write credits; a B response with nothing outstanding is dropped
   always_comb begin
      case ({grant_s, b_dec_s})
         2'b10:   credits_d = credits_q + CRED_ONE;
         2'b01:   credits_d = credits_q - CRED_ONE;
         default: credits_d = credits_q;
      endcase
   end

   // state, handshake and payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awid_q    <= {ID_WIDTH{1'b0}};
         awaddr_q  <= {ADDR_WIDTH{1'b0}};
         wdata_q   <= {WORD_W{1'b0}};
         credits_q <= {CRED_W{1'b0}};
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         awid_q    <= awid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         credits_q <= credits_d;
      end
   end

endmodule
